axi_wr_master: RTL and testbench
================================

# axi_wr_master

AXI4 write-channel master: accepts a single command (start address, beat count), pulls a data stream, and emits it as full-width INCR bursts. Bursts are capped at MAX_BURST_LEN beats and never cross a 4 KB boundary. It is the initiator-side counterpart to the AXI RAM responder and sits between stream producers (DMA, capture) and the AXI interconnect.

## Interface
- DATA_WIDTH, 32, AXI data width
- ADDR_WIDTH, 16, AXI address width; must be ≥ 12
- STRB_WIDTH, DATA_WIDTH/8, byte lanes; must be a power of two
- ID_WIDTH, 8, AXI ID width
- AXI_ID, 0, constant driven on awid
- MAX_BURST_LEN, 16, beats per burst; range 1..256
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored (forced 0)
- cmd_len  in  16  beat count minus 1
- s_data  in  DATA_WIDTH  write data stream
- s_strb  in  STRB_WIDTH  byte strobes, passed through to wstrb
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- sts_valid  out  1  one-cycle pulse, command complete
- sts_error  out  1  any bresp ≠ OKAY during the command; valid with sts_valid
- m_axi_awid / awaddr / awlen / awsize / awburst  out  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  AW payload
- m_axi_awvalid  out  1; m_axi_awready  in  1
- m_axi_wdata / wstrb / wlast  out  DATA_WIDTH / STRB_WIDTH / 1  W payload
- m_axi_wvalid  out  1; m_axi_wready  in  1
- m_axi_bid / bresp  in  ID_WIDTH / 2; m_axi_bvalid  in  1; m_axi_bready  out  1
- awlock, awcache and awprot are not ports; the top level ties them to 0.

## Operation
- FSM states: IDLE → ADDR → DATA → RESP, then back to ADDR or IDLE. Only one burst is outstanding at a time.
- **IDLE:** cmd_ready=1. On cmd_valid, latch the aligned address and rem = cmd_len+1 (17 bits), clear the error flag, go to ADDR.
- **ADDR:** awvalid=1.
  - burst = min(rem, MAX_BURST_LEN, (4096 − addr[11:0]) >> log2(STRB_WIDTH)).
  - awlen = burst−1, awsize = log2(STRB_WIDTH), awburst = 2'b01, awid = AXI_ID.
  - The payload is registered and held stable until awready.
  - On handshake: beat counter = burst−1, go to DATA.
- **DATA:** wvalid = s_valid, s_ready = wready, wdata/wstrb pass through, wlast = (beat counter == 0).
  - Counter decrements on each W handshake.
  - After the last beat: rem −= burst, addr += burst·STRB_WIDTH (modulo 2^ADDR_WIDTH), go to RESP.
- **RESP:** bready=1. On bvalid, error |= (bresp ≠ 2'b00).
  - If rem > 0, go to ADDR.
  - Otherwise go to IDLE and pulse sts_valid with sts_error.
- Outside DATA: s_ready=0 and wvalid=0. Outside RESP: bready=0. An early bvalid is left pending.
- A bresp error does not abort the command; remaining bursts are still issued.

## Timing
- All outputs are 0 while rst is high, including cmd_ready. cmd_ready rises the first cycle after rst deasserts.
- Command accepted in cycle N → awvalid in cycle N+1.
- AW handshake in cycle M → wvalid may assert in M+1.
- Last W handshake in cycle K → bready in K+1.
- B handshake in cycle J:
  - next burst: awvalid in J+1, or
  - last burst: sts_valid and cmd_ready in J+1.
- Zero-bubble W path: one beat per cycle when s_valid and wready are both held high.
- rst mid-command abandons it. Next cycle: no sts_valid, all valids and readys 0.
- cmd_valid while busy is ignored (cmd_ready=0).

## Configuration
- AXI_WR_MASTER_BID_CHECK_EN defined: a bid ≠ AXI_ID at the B handshake also sets the error flag.
- Undefined: bid is ignored.

## Structure
- Package axi_pkg holds:
  - AXI_BURST_FIXED/INCR/WRAP
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR
  - AXI_4K_BYTES = 4096
  - the FSM state enum
- One sub-module, axi_burst_len_calc: combinational min(rem, MAX_BURST_LEN, beats-to-4 KB).

## Test plan
- **Single burst:** cmd addr 0x0100, len 3, MAX 16 → one AW with awaddr 0x0100, awlen 3, awsize 2, awburst 01. Four W beats, wlast on beat 4. sts_error 0.
- **Split by length:** addr 0x0000, len 39 → bursts at awaddr 0x0000/0x0040/0x0080 with awlen 15/15/7. Exactly one sts_valid.
- **4 KB split:** addr 0x0FF8, len 3 → AW 0x0FF8 awlen 1, then AW 0x1000 awlen 1.
- **Error response:** bresp 2'b10 on burst 1 of 2 → burst 2 still issued, sts_error 1. With the macro defined, bid 0x05 when AXI_ID=0 → sts_error 1.
- **Backpressure:** random gaps on wready, awready and s_valid → data order and strobes preserved; awaddr stable while awvalid && !awready.
- **Reset mid-command:** rst for 1 cycle mid-DATA → awvalid, wvalid, bready and sts_valid 0 next cycle; cmd_ready 1 the cycle after release.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_pkg : AXI4 burst/response encodings and write-master states  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_4K_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_burst_len_calc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_burst_len_calc : min(rem, MAX_BURST_LEN, beats to 4 KB edge) |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_burst_len_calc
  import axi_pkg::*;
#(
  parameter int MAX_BURST_LEN = 16,
  parameter int STRB_WIDTH    = 4
) (
  input  logic [11:0] i_addr_lo,
  input  logic [16:0] i_rem,
  output logic [8:0]  o_burst
);

  localparam int c_LOG2_STRB = $clog2(STRB_WIDTH);

  logic [12:0] w_bytes_to_4k;
  logic [12:0] w_beats_to_4k;
  logic [8:0]  w_min_len;

  assign w_bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, i_addr_lo};
  assign w_beats_to_4k = w_bytes_to_4k >> c_LOG2_STRB;

  assign w_min_len = (i_rem < 17'(MAX_BURST_LEN)) ? i_rem[8:0] : 9'(MAX_BURST_LEN);
  // When the 4 KB limit wins it is below w_min_len, so it fits in 9 bits.
  assign o_burst   = ({4'b0, w_min_len} <= w_beats_to_4k) ? w_min_len : w_beats_to_4k[8:0];

endmodule
`default_nettype wire

// File: rtl/axi_wr_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_wr_master : command-driven AXI4 INCR write master, one burst |
// | in flight. Option: AXI_WR_MASTER_BID_CHECK_EN flags bid mismatch.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_wr_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_len,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [STRB_WIDTH-1:0] s_strb,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  sts_valid,
  output logic                  sts_error,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int                    c_LOG2_STRB  = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  wr_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [16:0]           r_rem;
  logic                  r_err;
  logic [7:0]            r_beat;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic [2:0]            r_awsize;
  logic [1:0]            r_awburst;
  logic [ID_WIDTH-1:0]   r_awid;
  logic                  r_awvalid;
  logic                  r_bready;
  logic                  r_cmd_ready;
  logic                  r_sts_valid;
  logic                  r_sts_error;

  logic                  w_in_data;
  logic                  w_cmd_fire;
  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_b_fire;
  logic                  w_b_err;
  logic                  w_enter_addr;
  logic [ADDR_WIDTH-1:0] w_calc_addr;
  logic [16:0]           w_calc_rem;
  logic [8:0]            w_burst;
  logic [8:0]            w_cur_beats;

  assign w_in_data  = (r_state == ST_DATA);
  assign w_cmd_fire = cmd_valid && r_cmd_ready;
  assign w_aw_fire  = r_awvalid && m_axi_awready;
  assign w_w_fire   = w_in_data && s_valid && m_axi_wready;
  assign w_b_fire   = r_bready && m_axi_bvalid;

`ifdef AXI_WR_MASTER_BID_CHECK_EN
  assign w_b_err = (m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != ID_WIDTH'(AXI_ID));
`else
  logic w_unused_bid;
  assign w_unused_bid = ^m_axi_bid;
  assign w_b_err      = (m_axi_bresp != AXI_RESP_OKAY);
`endif

  // The next burst is sized from the fresh command in IDLE, else from the running state.
  assign w_calc_addr  = (r_state == ST_IDLE) ? (cmd_addr & c_ALIGN_MASK) : r_addr;
  assign w_calc_rem   = (r_state == ST_IDLE) ? ({1'b0, cmd_len} + 17'd1) : r_rem;
  assign w_enter_addr = ((r_state == ST_IDLE) && w_cmd_fire) ||
                        ((r_state == ST_RESP) && w_b_fire && (r_rem != 17'd0));
  assign w_cur_beats  = {1'b0, r_awlen} + 9'd1;

  axi_burst_len_calc #(
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .STRB_WIDTH    (STRB_WIDTH)
  ) u_len_calc (
    .i_addr_lo (w_calc_addr[11:0]),
    .i_rem     (w_calc_rem),
    .o_burst   (w_burst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_err       <= 1'b0;
      r_beat      <= '0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_awsize    <= '0;
      r_awburst   <= '0;
      r_awid      <= '0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_sts_valid <= 1'b0;
      r_sts_error <= 1'b0;
    end else begin
      r_sts_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            r_addr      <= w_calc_addr;
            r_rem       <= w_calc_rem;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_beat    <= r_awlen;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_w_fire) begin
            if (r_beat == 8'd0) begin
              r_rem    <= r_rem - {8'b0, w_cur_beats};
              r_addr   <= r_addr + ADDR_WIDTH'({23'b0, w_cur_beats} << c_LOG2_STRB);
              r_bready <= 1'b1;
              r_state  <= ST_RESP;
            end else begin
              r_beat <= r_beat - 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (w_b_fire) begin
            r_bready <= 1'b0;
            r_err    <= r_err | w_b_err;
            if (r_rem != 17'd0) begin
              r_state <= ST_ADDR;
            end else begin
              r_state     <= ST_IDLE;
              r_sts_valid <= 1'b1;
              r_sts_error <= r_err | w_b_err;
              r_cmd_ready <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_enter_addr) begin
        r_awaddr  <= w_calc_addr;
        r_awlen   <= 8'(w_burst - 9'd1);
        r_awsize  <= 3'(c_LOG2_STRB);
        r_awburst <= AXI_BURST_INCR;
        r_awid    <= ID_WIDTH'(AXI_ID);
        r_awvalid <= 1'b1;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign sts_valid     = r_sts_valid;
  assign sts_error     = r_sts_error;
  assign m_axi_awid    = r_awid;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = r_awsize;
  assign m_axi_awburst = r_awburst;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_bready  = r_bready;

  assign s_ready      = w_in_data && m_axi_wready;
  assign m_axi_wvalid = w_in_data && s_valid;
  assign m_axi_wdata  = w_in_data ? s_data : '0;
  assign m_axi_wstrb  = w_in_data ? s_strb : '0;
  assign m_axi_wlast  = w_in_data && (r_beat == 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_wr_master : randomized scoreboard bench for axi_wr_master |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_axi_wr_master;
  import axi_pkg::*;

  localparam int DW = 32, AW = 16, SW = 4, IW = 8, MAXB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [15:0]   cmd_len = '0;
  logic [DW-1:0] s_data = '0;
  logic [SW-1:0] s_strb = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          sts_valid, sts_error;
  logic [IW-1:0] m_axi_awid;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [IW-1:0] m_axi_bid = '0;
  logic [1:0]    m_axi_bresp = '0;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;

  axi_wr_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
    .AXI_ID(0), .MAX_BURST_LEN(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid), .s_ready(s_ready),
    .sts_valid(sts_valid), .sts_error(sts_error),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct { logic [15:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct { logic [1:0] resp; logic [7:0] id; } b_t;

  aw_t  exp_aw[$];
  w_t   exp_w[$];
  w_t   src_q[$];
  b_t   resp_q[$];
  logic exp_sts[$];
  int   w_cycles[$];

  int n_tests = 0, n_fail = 0;
  int sts_seen = 0, w_hs_count = 0, cyc = 0, b_pending = 0, rdy_pct = 70;
  bit aborting = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Bus-side responders: inputs change just after posedge, decisions use the prior negedge sample.
  always begin
    @(posedge clk); #1;
    m_axi_awready = aborting ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    m_axi_wready  = aborting ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
  end

  always begin : p_src
    bit f;
    @(negedge clk); f = s_valid && s_ready;
    @(posedge clk); #1;
    if (aborting) begin
      src_q.delete();
      s_valid = 1'b0;
    end else begin
      if (f && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && $urandom_range(0, 99) < rdy_pct) begin
        s_valid = 1'b1;
        s_data  = src_q[0].data;
        s_strb  = src_q[0].strb;
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  always begin : p_bslave
    bit f, wl;
    b_t r;
    @(negedge clk);
    f  = m_axi_bvalid && m_axi_bready;
    wl = m_axi_wvalid && m_axi_wready && m_axi_wlast;
    @(posedge clk); #1;
    if (aborting) begin
      m_axi_bvalid = 1'b0;
      b_pending    = 0;
      resp_q.delete();
    end else begin
      if (wl) b_pending++;
      if (f) m_axi_bvalid = 1'b0;
      if (!m_axi_bvalid && b_pending > 0 && resp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        r = resp_q.pop_front();
        m_axi_bresp  = r.resp;
        m_axi_bid    = r.id;
        m_axi_bvalid = 1'b1;
        b_pending--;
      end
    end
  end

  // Monitor: compare every DUT output event against the scoreboard queues.
  always begin : p_mon
    bit b_due, bready_due;
    @(negedge clk);
    cyc++;
    if (aborting || rst) begin
      b_due = 0;
      bready_due = 0;
    end else begin
      if (b_due) check("next_aw_or_sts_after_b", {63'b0, m_axi_awvalid || sts_valid}, 64'd1);
      if (bready_due) check("bready_after_wlast", {63'b0, m_axi_bready}, 64'd1);
      b_due      = m_axi_bvalid && m_axi_bready;
      bready_due = m_axi_wvalid && m_axi_wready && m_axi_wlast;
      if (m_axi_awvalid) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
        else begin
          check("aw_payload",
                {27'b0, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst},
                {27'b0, 8'h00, exp_aw[0].addr, exp_aw[0].len, 3'd2, 2'b01});
          if (m_axi_awready) void'(exp_aw.pop_front());
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs_count++;
        w_cycles.push_back(cyc);
        if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
        else begin
          check("w_beat", {27'b0, m_axi_wdata, m_axi_wstrb, m_axi_wlast},
                {27'b0, exp_w[0].data, exp_w[0].strb, exp_w[0].last});
          void'(exp_w.pop_front());
        end
      end
      if (sts_valid) begin
        sts_seen++;
        if (exp_sts.size() == 0) check("sts_unexpected", 64'd1, 64'd0);
        else check("sts_error_ready", {62'b0, sts_error, cmd_ready}, {62'b0, exp_sts.pop_front(), 1'b1});
      end
    end
  end

  // Reference model: plans bursts from the command with plain arithmetic, then drives it.
  task automatic run_cmd(input logic [15:0] addr, input logic [15:0] len, input int mode, input bit wait_sts);
    int a, rem, b, tk, nb, t, target;
    bit err, acc;
    aw_t e;
    w_t w;
    b_t r;
    @(posedge clk); #2;
    a = int'(addr) & 32'hFFFC; rem = int'(len) + 1; nb = 0; err = 0;
    target = sts_seen + 1;
    while (rem > 0) begin
      b  = (rem < MAXB) ? rem : MAXB;
      tk = (4096 - (a % 4096)) / SW;
      if (tk < b) b = tk;
      e.addr = 16'(a); e.len = 8'(b - 1);
      exp_aw.push_back(e);
      for (int i = 0; i < b; i++) begin
        w.data = $urandom; w.strb = 4'($urandom); w.last = (i == b - 1);
        exp_w.push_back(w);
        src_q.push_back(w);
      end
      r.resp = AXI_RESP_OKAY; r.id = 8'h00;
      if (mode == 0) begin
        if ($urandom_range(0, 5) == 0) r.resp = AXI_RESP_SLVERR;
        if ($urandom_range(0, 5) == 0) r.id = 8'h05;
      end else if (mode == 2 && nb == 0) r.resp = AXI_RESP_SLVERR;
      else if (mode == 3 && nb == 0) r.id = 8'h05;
      err = err | (r.resp != AXI_RESP_OKAY);
`ifdef AXI_WR_MASTER_BID_CHECK_EN
      err = err | (r.id != 8'h00);
`endif
      resp_q.push_back(r);
      a = (a + b * SW) % 65536; rem -= b; nb++;
    end
    exp_sts.push_back(err);

    cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    acc = 0; t = 0;
    while (!acc && t < 200) begin
      @(negedge clk); acc = cmd_ready; t++;
    end
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_len = $urandom;
    if (!acc) check("cmd_accept_timeout", 64'd0, 64'd1);
    else begin
      @(negedge clk);
      check("aw_next_cycle_busy", {62'b0, m_axi_awvalid, cmd_ready}, 64'b10);
    end
    if (wait_sts) begin
      t = 0;
      while (sts_seen < target && t < 5000) begin
        @(negedge clk); t++;
      end
      if (sts_seen < target) check("sts_timeout", 64'd0, 64'd1);
      check("aw_drained", 64'(exp_aw.size()), 64'd0);
      check("w_drained", 64'(exp_w.size()), 64'd0);
    end
  endtask

  initial begin : p_main
    int t, start;
    logic [15:0] ra;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {58'b0, cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, sts_valid, s_ready}, 64'd0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk); check("cmd_ready_release_cycle", {63'b0, cmd_ready}, 64'd0);
    @(negedge clk); check("cmd_ready_after_release", {63'b0, cmd_ready}, 64'd1);

    run_cmd(16'h0100, 16'd3, 1, 1);
    run_cmd(16'h0000, 16'd39, 1, 1);
    run_cmd(16'h0FF8, 16'd3, 1, 1);
    run_cmd(16'h0000, 16'd31, 2, 1);
    run_cmd(16'h0043, 16'd31, 3, 1);
    run_cmd(16'hFFF0, 16'd9, 0, 1);

    rdy_pct = 100;
    w_cycles.delete();
    run_cmd(16'h0200, 16'd15, 1, 1);
    check("zero_bubble_beats", 64'(w_cycles.size()), 64'd16);
    if (w_cycles.size() == 16) check("zero_bubble_span", 64'(w_cycles[15] - w_cycles[0]), 64'd15);

    for (int i = 0; i < 20; i++) begin
      rdy_pct = $urandom_range(30, 100);
      ra = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = {4'($urandom), 12'hFC0 | 12'($urandom_range(0, 63))};
      run_cmd(ra, 16'($urandom_range(0, 90)), 0, 1);
    end

    rdy_pct = 80;
    run_cmd(16'h2000, 16'd60, 1, 0);
    start = w_hs_count; t = 0;
    while (w_hs_count < start + 3 && t < 2000) begin
      @(negedge clk); t++;
    end
    if (w_hs_count < start + 3) check("mid_cmd_w_timeout", 64'd0, 64'd1);
    @(posedge clk); #2; rst = 1'b1; aborting = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    check("abort_outputs_zero", {58'b0, cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, sts_valid, s_ready}, 64'd0);
    @(negedge clk);
    check("abort_cmd_ready", {62'b0, cmd_ready, sts_valid}, 64'b10);
    exp_aw.delete(); exp_w.delete(); exp_sts.delete();
    @(posedge clk); #2; aborting = 1'b0;

    run_cmd(16'h3FF0, 16'd20, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #600000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
